// File: rtl/alu_op_decoder.sv
// MIPS instruction to ALU operation-select decoder, registered into EX.
// Produces op code, operand selects, extended immediate and shift amount.
module alu_op_decoder #(
    parameter int NB_BITS  = 32,
    parameter int NB_OPE   = 4,
    parameter int NB_INSTR = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NB_INSTR-1:0] i_instr,
    input  logic                i_valid,
    input  logic                i_stall,
    input  logic                i_flush,
    output logic [NB_OPE-1:0]   o_ope_sel,
    output logic [1:0]          o_a_sel,
    output logic                o_b_sel,
    output logic [NB_BITS-1:0]  o_imm,
    output logic [4:0]          o_shamt,
    output logic                o_valid,
    output logic                o_illegal
);

    localparam logic [NB_OPE-1:0] OP_AND = NB_OPE'(0);
    localparam logic [NB_OPE-1:0] OP_OR  = NB_OPE'(1);
    localparam logic [NB_OPE-1:0] OP_ADD = NB_OPE'(2);
    localparam logic [NB_OPE-1:0] OP_XOR = NB_OPE'(3);
    localparam logic [NB_OPE-1:0] OP_SUB = NB_OPE'(6);
    localparam logic [NB_OPE-1:0] OP_SLT = NB_OPE'(7);
    localparam logic [NB_OPE-1:0] OP_SLL = NB_OPE'(8);
    localparam logic [NB_OPE-1:0] OP_SRL = NB_OPE'(9);
    localparam logic [NB_OPE-1:0] OP_SRA = NB_OPE'(10);
    localparam logic [NB_OPE-1:0] OP_NOR = NB_OPE'(12);
    localparam logic [NB_OPE-1:0] OP_JAL = NB_OPE'(13);
    localparam logic [NB_OPE-1:0] OP_LUI = NB_OPE'(14);

    localparam logic [1:0] A_RS    = 2'd0;
    localparam logic [1:0] A_SHAMT = 2'd1;
    localparam logic [1:0] A_PC4   = 2'd2;

    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [15:0]        imm16;
    logic [NB_BITS-1:0] imm_sext;
    logic [NB_BITS-1:0] imm_zext;

    logic [NB_OPE-1:0]  dec_ope;
    logic [1:0]         dec_a_sel;
    logic               dec_b_sel;
    logic [NB_BITS-1:0] dec_imm;
    logic               dec_illegal;

    // rs/rt/rd fields are consumed by the register file, not here
    logic unused_fields;
    assign unused_fields = ^i_instr[25:16];

    assign opcode   = i_instr[31:26];
    assign funct    = i_instr[5:0];
    assign imm16    = i_instr[15:0];
    assign imm_sext = {{(NB_BITS-16){imm16[15]}}, imm16};
    assign imm_zext = {{(NB_BITS-16){1'b0}}, imm16};

    always_comb begin
        dec_ope     = OP_AND;
        dec_a_sel   = A_RS;
        dec_b_sel   = 1'b0;
        dec_imm     = '0;
        dec_illegal = 1'b0;
        unique case (opcode)
            6'h00: begin
                unique case (funct)
                    6'h00: begin dec_ope = OP_SLL; dec_a_sel = A_SHAMT; end
                    6'h02: begin dec_ope = OP_SRL; dec_a_sel = A_SHAMT; end
                    6'h03: begin dec_ope = OP_SRA; dec_a_sel = A_SHAMT; end
                    6'h04: dec_ope = OP_SLL;
                    6'h06: dec_ope = OP_SRL;
                    6'h07: dec_ope = OP_SRA;
                    6'h08: dec_ope = OP_ADD;
                    6'h09: begin dec_ope = OP_JAL; dec_a_sel = A_PC4; end
                    6'h21: dec_ope = OP_ADD;
                    6'h23: dec_ope = OP_SUB;
                    6'h24: dec_ope = OP_AND;
                    6'h25: dec_ope = OP_OR;
                    6'h26: dec_ope = OP_XOR;
                    6'h27: dec_ope = OP_NOR;
                    6'h2A: dec_ope = OP_SLT;
                    default: dec_illegal = 1'b1;
                endcase
            end
            6'h09: begin dec_ope = OP_ADD; dec_b_sel = 1'b1; dec_imm = imm_sext; end
            6'h0A: begin dec_ope = OP_SLT; dec_b_sel = 1'b1; dec_imm = imm_sext; end
            6'h0C: begin dec_ope = OP_AND; dec_b_sel = 1'b1; dec_imm = imm_zext; end
            6'h0D: begin dec_ope = OP_OR;  dec_b_sel = 1'b1; dec_imm = imm_zext; end
            6'h0E: begin dec_ope = OP_XOR; dec_b_sel = 1'b1; dec_imm = imm_zext; end
            6'h0F: begin dec_ope = OP_LUI; dec_b_sel = 1'b1; dec_imm = imm_zext; end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
            6'h28, 6'h29, 6'h2B: begin
                dec_ope   = OP_ADD;
                dec_b_sel = 1'b1;
                dec_imm   = imm_sext;
            end
            6'h04, 6'h05: begin dec_ope = OP_SUB; dec_imm = imm_sext; end
            6'h03: begin dec_ope = OP_JAL; dec_a_sel = A_PC4; end
            6'h02: dec_ope = OP_ADD;
            default: dec_illegal = 1'b1;
        endcase
    end

    // Flush shares the reset path so a bubble is indistinguishable from reset
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            o_ope_sel <= '0;
            o_a_sel   <= '0;
            o_b_sel   <= 1'b0;
            o_imm     <= '0;
            o_shamt   <= '0;
            o_valid   <= 1'b0;
            o_illegal <= 1'b0;
        end else if (!i_stall) begin
            o_ope_sel <= i_valid ? dec_ope     : '0;
            o_a_sel   <= i_valid ? dec_a_sel   : '0;
            o_b_sel   <= i_valid ? dec_b_sel   : 1'b0;
            o_imm     <= i_valid ? dec_imm     : '0;
            o_shamt   <= i_valid ? i_instr[10:6] : '0;
            o_valid   <= i_valid;
            o_illegal <= i_valid ? dec_illegal : 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed-vector bench for alu_op_decoder.
// Expected values are hand-decoded from the MIPS encodings.
module tb_alu_op_decoder;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        valid;
    logic        stall;
    logic        flush;
    logic [3:0]  ope_sel;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    alu_op_decoder #(
        .NB_BITS(32),
        .NB_OPE(4),
        .NB_INSTR(32)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_instr(instr),
        .i_valid(valid),
        .i_stall(stall),
        .i_flush(flush),
        .o_ope_sel(ope_sel),
        .o_a_sel(a_sel),
        .o_b_sel(b_sel),
        .o_imm(imm),
        .o_shamt(shamt),
        .o_valid(out_valid),
        .o_illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".ope"}, 32'(ope_sel), 32'd0);
        chk({tag, ".a"}, 32'(a_sel), 32'd0);
        chk({tag, ".b"}, 32'(b_sel), 32'd0);
        chk({tag, ".imm"}, imm, 32'd0);
        chk({tag, ".shamt"}, 32'(shamt), 32'd0);
        chk({tag, ".valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".ill"}, 32'(illegal), 32'd0);
    endtask

    task automatic load(input logic [31:0] ins);
        instr = ins;
        valid = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        step();
    endtask

    initial begin
        rst   = 1'b1;
        instr = 32'h2528FFFF;
        valid = 1'b1;
        stall = 1'b0;
        flush = 1'b0;

        step();
        chk_zero("rst1");
        step();
        chk_zero("rst2");
        rst = 1'b0;
        step();
        chk("rel.valid", 32'(out_valid), 32'd1);
        chk("rel.ope", 32'(ope_sel), 32'd2);

        load(32'h00031080);
        chk("sll.ope", 32'(ope_sel), 32'd8);
        chk("sll.a", 32'(a_sel), 32'd1);
        chk("sll.b", 32'(b_sel), 32'd0);
        chk("sll.shamt", 32'(shamt), 32'd2);

        load(32'h00431004);
        chk("sllv.ope", 32'(ope_sel), 32'd8);
        chk("sllv.a", 32'(a_sel), 32'd0);

        load(32'h2528FFFF);
        chk("addiu.ope", 32'(ope_sel), 32'd2);
        chk("addiu.b", 32'(b_sel), 32'd1);
        chk("addiu.imm", imm, 32'hFFFFFFFF);
        chk("addiu.shamt", 32'(shamt), 32'd31);

        load(32'h3128FFFF);
        chk("andi.ope", 32'(ope_sel), 32'd0);
        chk("andi.imm", imm, 32'h0000FFFF);

        load(32'h3C011234);
        chk("lui.ope", 32'(ope_sel), 32'd14);
        chk("lui.imm", imm, 32'h00001234);

        load(32'h8C22FFF8);
        chk("lw.ope", 32'(ope_sel), 32'd2);
        chk("lw.imm", imm, 32'hFFFFFFF8);

        load(32'h0C000010);
        chk("jal.ope", 32'(ope_sel), 32'd13);
        chk("jal.a", 32'(a_sel), 32'd2);
        chk("jal.b", 32'(b_sel), 32'd0);

        load(32'h0060F809);
        chk("jalr.ope", 32'(ope_sel), 32'd13);
        chk("jalr.a", 32'(a_sel), 32'd2);

        load(32'h10220003);
        chk("beq.ope", 32'(ope_sel), 32'd6);
        chk("beq.b", 32'(b_sel), 32'd0);
        chk("beq.imm", imm, 32'h00000003);

        load(32'h00221821);
        chk("addu.ope", 32'(ope_sel), 32'd2);
        instr = 32'h00221823;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.ope", 32'(ope_sel), 32'd2);
            chk("stall.valid", 32'(out_valid), 32'd1);
        end
        stall = 1'b0;
        step();
        chk("unstall.ope", 32'(ope_sel), 32'd6);

        stall = 1'b1;
        flush = 1'b1;
        step();
        chk_zero("stflush");
        flush = 1'b0;
        stall = 1'b0;

        load(32'h00431004);
        valid = 1'b0;
        instr = 32'h2528FFFF;
        step();
        chk_zero("bubble");

        load(32'h2528FFFF);
        stall = 1'b1;
        step();
        chk("pre_rst.imm", imm, 32'hFFFFFFFF);
        rst = 1'b1;
        step();
        chk_zero("rst_stall");
        rst   = 1'b0;
        stall = 1'b0;

        load(32'hFC000000);
        chk("ill_op.ill", 32'(illegal), 32'd1);
        chk("ill_op.ope", 32'(ope_sel), 32'd0);
        chk("ill_op.valid", 32'(out_valid), 32'd1);
        chk("ill_op.imm", imm, 32'd0);

        load(32'h0000003F);
        chk("ill_fn.ill", 32'(illegal), 32'd1);
        chk("ill_fn.ope", 32'(ope_sel), 32'd0);

        load(32'h00221825);
        chk("or.ill", 32'(illegal), 32'd0);
        chk("or.ope", 32'(ope_sel), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_decoder.md
Name: alu_op_decoder

Overview:
- ID/EX-side producer of the ALU operation-select interface: decodes a 32-bit MIPS instruction into the 4-bit ALU op code, operand-source selects, extended immediate and shift amount.
- Registers the result into the EX stage.
- Sits between the IF/ID register and the EX-stage ALU.
- Supports pipeline stall (hold) and flush (bubble insertion).

Parameters:
- NB_BITS, 32, data/immediate width
- NB_OPE, 4, ALU op-select width
- NB_INSTR, 32, instruction width

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_instr  in  NB_INSTR  instruction from IF/ID
- i_valid  in  1  i_instr holds a real instruction
- i_stall  in  1  hold all outputs this cycle
- i_flush  in  1  replace the next output with a bubble
- o_ope_sel  out  NB_OPE  ALU op code
- o_a_sel  out  2  ALU A source: 0=rs, 1=shamt zero-extended, 2=PC+4
- o_b_sel  out  1  ALU B source: 0=rt, 1=o_imm
- o_imm  out  NB_BITS  extended immediate
- o_shamt  out  5  instr[10:6]
- o_valid  out  1  outputs describe a real instruction
- o_illegal  out  1  opcode/funct not decodable

Behaviour:
- ALU op codes: AND=0, OR=1, ADD=2, XOR=3, SUB=6, SLT=7, SLL=8, SRL=9, SRA=10, NOR=12, JAL=13, LUI=14.
- Latency is 1 cycle: outputs reflect i_instr sampled at the previous edge. Decode logic is combinational; all outputs are registered.
- Reset (i_rst=1 at edge): all outputs are 0. This gives o_ope_sel=AND, o_valid=0, o_illegal=0. Reset wins over flush and stall.
- Priority each edge: i_rst > i_flush > i_stall > load.
  - Flush: all outputs are 0, identical to reset.
  - Stall: all registers hold.
  - Load: all registers take the decoded values, and o_valid takes i_valid.
- When i_valid=0 on load: all outputs are 0, a bubble.
- R-type (opcode 0x00), decoded by funct:
  - 0x00 SLL, 0x02 SRL, 0x03 SRA: a_sel=1.
  - 0x04 SLLV, 0x06 SRLV, 0x07 SRAV: same ops, a_sel=0.
  - 0x21 ADD, 0x23 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT.
  - 0x09 JALR: JAL with a_sel=2.
  - 0x08 JR: ADD.
  - All R-type use b_sel=0.
- I-type (b_sel=1):
  - 0x09 ADD, imm sign-extended.
  - 0x0A SLT, sign-extended.
  - 0x0C AND, 0x0D OR, 0x0E XOR: zero-extended.
  - 0x0F LUI: imm zero-extended; the ALU performs the shift.
  - Loads 0x20/0x21/0x23/0x24/0x25 and stores 0x28/0x29/0x2B: ADD, sign-extended.
- Branches 0x04/0x05: SUB, b_sel=0, imm sign-extended.
- Jumps:
  - 0x03 JAL: JAL, a_sel=2, b_sel=0.
  - 0x02 J: ADD, no ALU use.
- Undefined opcode or R-type funct: o_illegal=1, o_ope_sel=0, a_sel=0, b_sel=0, o_imm=0. o_valid still follows i_valid.
- o_shamt is always instr[10:6] for any valid load, regardless of type.
- Sign extension replicates instr[15] into bits NB_BITS-1:16. Zero extension fills those bits with 0.
- Stall held for N cycles: outputs unchanged for N cycles. The first edge with stall=0 loads the then-current i_instr.
- Stall and flush together: flush wins.
- Reset asserted mid-stall: outputs are cleared at that edge.

Test Plan:
- Reset: i_rst=1 for 2 cycles with i_instr=0x2528FFFF, i_valid=1 -> all outputs 0 during reset. First edge after release -> o_valid=1, o_ope_sel=2.
- Shifts:
  - 0x00031080 (sll $2,$3,2) -> o_ope_sel=8, a_sel=1, b_sel=0, o_shamt=2.
  - 0x00431004 (sllv) -> o_ope_sel=8, a_sel=0.
- Immediates:
  - 0x2528FFFF (addiu) -> ope=2, b_sel=1, o_imm=0xFFFFFFFF.
  - 0x3128FFFF (andi) -> ope=0, o_imm=0x0000FFFF.
  - 0x3C011234 (lui) -> ope=14, o_imm=0x00001234.
- Control flow:
  - 0x0C000010 (jal) -> ope=13, a_sel=2.
  - 0x10220003 (beq) -> ope=6, b_sel=0, o_imm=0x00000003.
- Stall/flush:
  - Load 0x00221821 (addu), then stall 3 cycles while i_instr=0x00221823 -> ope stays 2. Release -> ope=6.
  - Stall and flush in the same cycle -> o_valid=0, all outputs 0.
- Illegal: 0xFC000000 -> o_illegal=1, o_ope_sel=0, o_valid=1. Then 0x0000003F -> o_illegal=1. Then a valid instruction -> o_illegal=0.
